name_stride_splitter: RTL and testbench

- Parametrised successor to the fixed-length name converter.
- Consumes an NDN name as a valid/ready stream of ASCII characters and splits it into strides. A new stride starts at every '/' or when a stride reaches STRIDE_LEN characters.
- Emits one stride per output beat, with length, index, last and error tags, to the FIB lookup pipeline.
- Adds reset, backpressure, name framing and overflow handling.

---
 rtl/ndn_name_pkg.sv | 19 +
 rtl/stride_out_reg.sv | 52 +++++
 rtl/name_stride_splitter.sv | 174 +++++++++++++++++
 tb/tb_name_stride_splitter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ndn_name_pkg.sv
// Shared types and constants for the NDN name-processing pipeline.
// Holds the character type, default characters, splitter FSM states and width helper.
package ndn_name_pkg;

    localparam int unsigned CHAR_SIZE_DEFAULT = 8;

    typedef logic [CHAR_SIZE_DEFAULT-1:0] char_t;

    localparam char_t DEFAULT_CHAR = 8'h00;
    localparam char_t DELIM_CHAR   = 8'h2F;

    typedef enum logic {ACCUM, TAIL} split_state_e;

    // Width needed to hold a count of 0..n inclusive.
    function automatic int unsigned stride_len_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stride_out_reg.sv
// Valid/ready output register for one stride (characters, length, index, last, error).
// Loads only when free; holds all fields stable until accepted downstream.
module stride_out_reg
    import ndn_name_pkg::*;
#(
    parameter int unsigned           CHAR_SIZE  = CHAR_SIZE_DEFAULT,
    parameter int unsigned           STRIDE_LEN = 8,
    parameter int unsigned           LEN_W      = 4,
    parameter int unsigned           IDX_W      = 3,
    parameter logic [CHAR_SIZE-1:0]  PAD_CHAR   = DEFAULT_CHAR
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load,
    input  logic [STRIDE_LEN*CHAR_SIZE-1:0] ld_stride,
    input  logic [LEN_W-1:0]                ld_len,
    input  logic [IDX_W-1:0]                ld_idx,
    input  logic                            ld_last,
    input  logic                            ld_err,
    output logic                            free,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [STRIDE_LEN*CHAR_SIZE-1:0] out_stride,
    output logic [LEN_W-1:0]                out_len,
    output logic [IDX_W-1:0]                out_idx,
    output logic                            out_last,
    output logic                            out_err
);

    assign free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_stride <= {STRIDE_LEN{PAD_CHAR}};
            out_len    <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
            out_err    <= 1'b0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_stride <= ld_stride;
            out_len    <= ld_len;
            out_idx    <= ld_idx;
            out_last   <= ld_last;
            out_err    <= ld_err;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/name_stride_splitter.sv
// Splits a streamed NDN name into strides at '/' or at STRIDE_LEN characters.
// Optional NAME_SPLITTER_STATS_EN adds name / truncated-name counters.
module name_stride_splitter
    import ndn_name_pkg::*;
#(
    parameter int unsigned          CHAR_SIZE   = CHAR_SIZE_DEFAULT,
    parameter int unsigned          STRIDE_LEN  = 8,
    parameter int unsigned          MAX_STRIDES = 4,
    parameter logic [CHAR_SIZE-1:0] DELIM       = DELIM_CHAR,
    parameter logic [CHAR_SIZE-1:0] PAD_CHAR    = DEFAULT_CHAR
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [CHAR_SIZE-1:0]                       in_char,
    input  logic                                       in_last,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [STRIDE_LEN*CHAR_SIZE-1:0]            out_stride,
    output logic [stride_len_w(STRIDE_LEN)-1:0]        out_len,
    output logic [stride_len_w(MAX_STRIDES)-1:0]       out_idx,
    output logic                                       out_last,
    output logic                                       out_err
`ifdef NAME_SPLITTER_STATS_EN
    ,
    output logic [15:0]                                stat_names,
    output logic [15:0]                                stat_ovf
`endif
);

    localparam int unsigned LEN_W = stride_len_w(STRIDE_LEN);
    localparam int unsigned IDX_W = stride_len_w(MAX_STRIDES);
    localparam int unsigned BUF_W = STRIDE_LEN * CHAR_SIZE;

    split_state_e     state_q, state_d;
    logic [BUF_W-1:0] acc_q, acc_d, new_acc;
    logic [LEN_W-1:0] acc_len_q, acc_len_d, new_len;
    logic [IDX_W-1:0] scnt_q, scnt_d;
    logic             ovf_q, ovf_d;

    logic             free, accept, flush, load;
    logic [BUF_W-1:0] ld_stride;
    logic [LEN_W-1:0] ld_len;
    logic             ld_last, ld_err;

    assign in_ready = (state_q == ACCUM) && free;
    assign accept   = in_valid && in_ready;
    assign flush    = (acc_len_q == LEN_W'(STRIDE_LEN)) ||
                      ((in_char == DELIM) && (acc_len_q != '0));

    // Accumulator contents after placing the incoming character.
    always_comb begin
        new_acc = acc_q;
        new_len = acc_len_q + LEN_W'(1);
        if (flush) begin
            new_acc                  = {STRIDE_LEN{PAD_CHAR}};
            new_acc[CHAR_SIZE-1:0]   = in_char;
            new_len                  = LEN_W'(1);
        end else begin
            for (int i = 0; i < int'(STRIDE_LEN); i++) begin
                if (acc_len_q == LEN_W'(i)) new_acc[i*CHAR_SIZE +: CHAR_SIZE] = in_char;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_len_d = acc_len_q;
        scnt_d    = scnt_q;
        ovf_d     = ovf_q;
        load      = 1'b0;
        ld_stride = acc_q;
        ld_len    = acc_len_q;
        ld_last   = 1'b0;
        ld_err    = 1'b0;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d     = new_acc;
                    acc_len_d = new_len;
                    if (flush) begin
                        // Strides past MAX_STRIDES are dropped; scnt saturates at MAX_STRIDES.
                        if (scnt_q < IDX_W'(MAX_STRIDES)) begin
                            load   = 1'b1;
                            scnt_d = scnt_q + IDX_W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                        if (in_last) state_d = TAIL;
                    end else if (in_last) begin
                        load      = 1'b1;
                        ld_stride = new_acc;
                        ld_len    = new_len;
                        ld_last   = 1'b1;
                        ld_err    = ovf_q;
                        acc_d     = {STRIDE_LEN{PAD_CHAR}};
                        acc_len_d = '0;
                        scnt_d    = '0;
                        ovf_d     = 1'b0;
                    end
                end
            end
            TAIL: begin
                if (free) begin
                    load      = 1'b1;
                    ld_last   = 1'b1;
                    ld_err    = ovf_q;
                    acc_d     = {STRIDE_LEN{PAD_CHAR}};
                    acc_len_d = '0;
                    scnt_d    = '0;
                    ovf_d     = 1'b0;
                    state_d   = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= {STRIDE_LEN{PAD_CHAR}};
            acc_len_q <= '0;
            scnt_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_len_q <= acc_len_d;
            scnt_q    <= scnt_d;
            ovf_q     <= ovf_d;
        end
    end

    stride_out_reg #(
        .CHAR_SIZE  (CHAR_SIZE),
        .STRIDE_LEN (STRIDE_LEN),
        .LEN_W      (LEN_W),
        .IDX_W      (IDX_W),
        .PAD_CHAR   (PAD_CHAR)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .ld_stride  (ld_stride),
        .ld_len     (ld_len),
        .ld_idx     (scnt_q),
        .ld_last    (ld_last),
        .ld_err     (ld_err),
        .free       (free),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_stride (out_stride),
        .out_len    (out_len),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .out_err    (out_err)
    );

`ifdef NAME_SPLITTER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_names <= '0;
            stat_ovf   <= '0;
        end else if (out_valid && out_ready && out_last) begin
            stat_names <= stat_names + 16'd1;
            if (out_err) stat_ovf <= stat_ovf + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_name_stride_splitter.sv
// Directed self-checking bench for name_stride_splitter with default parameters.
module tb_name_stride_splitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [7:0]  in_char;
    logic        out_valid, out_ready, out_last, out_err;
    logic [63:0] out_stride;
    logic [3:0]  out_len;
    logic [2:0]  out_idx;
`ifdef NAME_SPLITTER_STATS_EN
    logic [15:0] stat_names, stat_ovf;
`endif

    always #5 clk = ~clk;

    name_stride_splitter dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_stride (out_stride),
        .out_len    (out_len),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .out_err    (out_err)
`ifdef NAME_SPLITTER_STATS_EN
        ,
        .stat_names (stat_names),
        .stat_ovf   (stat_ovf)
`endif
    );

    typedef struct {
        logic [63:0] stride;
        logic [3:0]  len;
        logic [2:0]  idx;
        logic        last;
        logic        err;
    } rec_t;

    rec_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Inputs change at posedge+1, so the negedge sees the values the next edge will use.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            q.push_back('{out_stride, out_len, out_idx, out_last, out_err});
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input string s);
        logic [63:0] v = '0;
        for (int i = 0; i < s.len(); i++) v[i*8 +: 8] = s[i];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s, input bit last_on_end, output int cycles);
        cycles = 0;
        for (int i = 0; i < s.len(); i++) begin
            int w = 0;
            in_valid = 1'b1;
            in_char  = s[i];
            in_last  = last_on_end && (i == s.len() - 1);
            forever begin
                @(negedge clk);
                cycles++;
                if (in_ready) begin
                    step();
                    break;
                end
                step();
                w++;
                if (w > 50) begin
                    check_eq({"accept timeout ", s}, 64'd0, 64'd1);
                    break;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_next(input string tag, input string s, input int idx,
                              input bit last, input bit err);
        rec_t r;
        if (q.size() == 0) begin
            check_eq({tag, " present"}, 64'd0, 64'd1);
        end else begin
            r = q.pop_front();
            check_eq({tag, " stride"}, r.stride, mk(s));
            check_eq({tag, " len"}, 64'(r.len), 64'(s.len()));
            check_eq({tag, " idx"}, 64'(r.idx), 64'(idx));
            check_eq({tag, " last/err"}, {62'd0, r.last, r.err}, {62'd0, last, err});
        end
    endtask

    task automatic check_empty(input string tag);
        check_eq({tag, " extra strides"}, 64'(q.size()), 64'd0);
        q.delete();
    endtask

    int cyc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        check_eq("rst out_valid", 64'(out_valid), 64'd0);
        check_eq("rst out_stride", out_stride, 64'd0);
        check_eq("rst out_len", 64'(out_len), 64'd0);
        check_eq("rst out_idx", 64'(out_idx), 64'd0);
        check_eq("rst out_last/err", {62'd0, out_last, out_err}, 64'd0);
        check_eq("rst in_ready", 64'(in_ready), 64'd1);

        // Delimiter splits.
        send_str("/a/bc", 1'b1, cyc);
        repeat (4) step();
        check_next("A0", "/a", 0, 1'b0, 1'b0);
        check_next("A1", "/bc", 1, 1'b1, 1'b0);
        check_empty("A");

        // Length split and full-rate throughput.
        send_str("/abcdefghij", 1'b1, cyc);
        check_eq("B throughput cycles", 64'(cyc), 64'd11);
        repeat (4) step();
        check_next("B0", "/abcdefg", 0, 1'b0, 1'b0);
        check_next("B1", "hij", 1, 1'b1, 1'b0);
        check_empty("B");

        // Trailing delimiter with in_last: two strides due, TAIL stalls input.
        send_str("/a/", 1'b1, cyc);
        check_eq("C tail in_ready", 64'(in_ready), 64'd0);
        step();
        check_eq("C after tail in_ready", 64'(in_ready), 64'd1);
        repeat (3) step();
        check_next("C0", "/a", 0, 1'b0, 1'b0);
        check_next("C1", "/", 1, 1'b1, 1'b0);
        check_empty("C");

        // Overflow: fifth non-final stride dropped, final flagged.
        send_str("/a/b/c/d/e/f", 1'b1, cyc);
        repeat (4) step();
        check_next("D0", "/a", 0, 1'b0, 1'b0);
        check_next("D1", "/b", 1, 1'b0, 1'b0);
        check_next("D2", "/c", 2, 1'b0, 1'b0);
        check_next("D3", "/d", 3, 1'b0, 1'b0);
        check_next("D4", "/f", 4, 1'b1, 1'b1);
        check_empty("D");

        // Backpressure mid-name.
        out_ready = 1'b0;
        send_str("/ab/", 1'b0, cyc);
        in_valid = 1'b1;
        in_char  = "c";
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("E stall in_ready", 64'(in_ready), 64'd0);
            check_eq("E stall out_valid", 64'(out_valid), 64'd1);
            check_eq("E stall out_stride", out_stride, mk("/ab"));
            check_eq("E stall out_len", 64'(out_len), 64'd3);
            step();
        end
        out_ready = 1'b1;
        send_str("cd/ef", 1'b1, cyc);
        repeat (4) step();
        check_next("E0", "/ab", 0, 1'b0, 1'b0);
        check_next("E1", "/cd", 1, 1'b0, 1'b0);
        check_next("E2", "/ef", 2, 1'b1, 1'b0);
        check_empty("E");

        // Reset mid-name with a stride pending in the output register.
        out_ready = 1'b0;
        send_str("/ab/", 1'b0, cyc);
        check_eq("F pending out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("F post-rst out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        send_str("/x", 1'b1, cyc);
        repeat (4) step();
        check_next("F0", "/x", 0, 1'b1, 1'b0);
        check_empty("F");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
